// File: rtl/seq_muldiv_w.sv
// Sequential multiply / divide unit.
// Unsigned and signed shift-add multiply (one multiplier bit per cycle) and
// restoring division of a 2W-bit dividend {C,A} by a W-bit divisor B.
// Ports:
//   CLK, RST_N         clock, synchronous active-low reset
//   START, MODE        request and operation (00 umul, 01 smul, 10 udiv, 11 umul)
//   A, B, C            operands (C is the dividend high half, division only)
//   BUSY, DONE         operation in progress / one-cycle result-valid pulse
//   RES_HI, RES_LO     product high/low half, or remainder/quotient
//   ZO, VO, NO         zero, overflow, negative flags
module seq_muldiv_w #(
    parameter int unsigned W         = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [1:0]   MODE,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RES_HI,
    output logic [W-1:0] RES_LO,
    output logic         ZO,
    output logic         VO,
    output logic         NO
);

    localparam int unsigned CW = $clog2(W + 2);
    localparam int unsigned W2 = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
    typedef enum logic [1:0] {OP_UMUL, OP_SMUL, OP_DIV} op_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    op_t            r_op;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_c;
    logic           r_neg;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_res_hi;
    logic [W-1:0]   r_res_lo;
    logic           r_zo;
    logic           r_vo;
    logic           r_no;

    op_t            w_op_in;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic           w_neg_in;
    logic           w_ovf_in;
    logic [W:0]     w_sh;
    logic [W-1:0]   w_mul_hi;
    logic [W-1:0]   w_mul_lo;
    logic           w_ge;
    logic [W-1:0]   w_trial;
    logic [W-1:0]   w_div_hi;
    logic [W-1:0]   w_div_lo;
    logic [W2-1:0]  w_prod;
    logic [W2-1:0]  w_prod_fix;
    logic           w_last_step;
    logic           w_finish;
    logic [W-1:0]   w_fin_hi;
    logic [W-1:0]   w_fin_lo;
    logic           w_fin_zo;
    logic           w_fin_vo;
    logic           w_fin_no;

    // Operation decode and operand conditioning at accept.
    always_comb begin
        w_op_in = OP_UMUL;
        case (MODE)
            2'b01:   w_op_in = SIGNED_EN ? OP_SMUL : OP_UMUL;
            2'b10:   w_op_in = OP_DIV;
            default: w_op_in = OP_UMUL;
        endcase
        w_a_mag  = ((w_op_in == OP_SMUL) && A[W-1]) ? (~A + W'(1)) : A;
        w_b_mag  = ((w_op_in == OP_SMUL) && B[W-1]) ? (~B + W'(1)) : B;
        w_neg_in = (w_op_in == OP_SMUL) && (A[W-1] ^ B[W-1]);
        w_ovf_in = (w_op_in == OP_DIV) && (C >= B);
    end

    // One shift-add multiply step: r_b is the multiplicand, r_lo the multiplier.
    always_comb begin
        w_sh     = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
        w_mul_hi = w_sh[W:1];
        w_mul_lo = {w_sh[0], r_lo[W-1:1]};
    end

    // One restoring divide step. The partial remainder is W+1 bits wide but the
    // difference always fits in W bits when the subtraction is taken.
    always_comb begin
        w_ge     = {r_hi, r_lo[W-1]} >= {1'b0, r_b};
        w_trial  = {r_hi[W-2:0], r_lo[W-1]} - r_b;
        w_div_hi = w_ge ? w_trial : {r_hi[W-2:0], r_lo[W-1]};
        w_div_lo = {r_lo[W-2:0], w_ge};
    end

    // Result and flags written on the DONE edge.
    always_comb begin
        w_prod      = {r_hi, r_lo};
        w_prod_fix  = r_neg ? (~w_prod + W2'(1)) : w_prod;
        w_last_step = (r_cnt == CW'(W - 1));
        w_finish    = ((r_state == S_RUN) && w_last_step && (r_op == OP_UMUL))
                      || (r_state == S_FIN);
        w_fin_hi    = w_prod_fix[W2-1:W];
        w_fin_lo    = w_prod_fix[W-1:0];
        w_fin_vo    = 1'b0;
        if (r_op == OP_DIV) begin
            w_fin_hi = r_ovf ? r_c : r_hi;
            w_fin_lo = r_ovf ? '1 : r_lo;
            w_fin_vo = r_ovf;
            w_fin_zo = (w_fin_lo == '0);
            w_fin_no = w_fin_lo[W-1];
        end else begin
            // Unsigned multiply finishes on its last step, no extra cycle.
            if (r_state == S_RUN) begin
                w_fin_hi = w_mul_hi;
                w_fin_lo = w_mul_lo;
            end
            w_fin_zo = (w_fin_hi == '0);
            w_fin_no = w_fin_hi[W-1];
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_step) w_state_nxt = (r_op == OP_UMUL) ? S_IDLE : S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Datapath, counter and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_op     <= OP_UMUL;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_zo     <= 1'b0;
            r_vo     <= 1'b0;
            r_no     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_op   <= w_op_in;
                        r_cnt  <= '0;
                        r_c    <= C;
                        r_neg  <= w_neg_in;
                        r_ovf  <= w_ovf_in;
                        r_busy <= 1'b1;
                        if (w_op_in == OP_DIV) begin
                            r_hi <= C;
                            r_lo <= A;
                            r_b  <= B;
                        end else begin
                            r_hi <= '0;
                            r_lo <= w_b_mag;
                            r_b  <= w_a_mag;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op == OP_DIV) begin
                        // An overflowed division keeps C in r_hi untouched.
                        if (!r_ovf) begin
                            r_hi <= w_div_hi;
                            r_lo <= w_div_lo;
                        end
                    end else begin
                        r_hi <= w_mul_hi;
                        r_lo <= w_mul_lo;
                    end
                end
                default: ;
            endcase
            if (w_finish) begin
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_res_hi <= w_fin_hi;
                r_res_lo <= w_fin_lo;
                r_zo     <= w_fin_zo;
                r_vo     <= w_fin_vo;
                r_no     <= w_fin_no;
            end
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RES_HI = r_res_hi;
    assign RES_LO = r_res_lo;
    assign ZO     = r_zo;
    assign VO     = r_vo;
    assign NO     = r_no;

endmodule

// File: tb/tb_seq_muldiv_w.sv
// Directed testbench for seq_muldiv_w at W=8.
module tb_seq_muldiv_w;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic [1:0] MODE;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RES_HI;
    logic [7:0] RES_LO;
    logic       ZO;
    logic       VO;
    logic       NO;

    int n_checks = 0;
    int n_fail   = 0;

    seq_muldiv_w #(.W(8), .SIGNED_EN(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE),
        .A(A), .B(B), .C(C),
        .BUSY(BUSY), .DONE(DONE), .RES_HI(RES_HI), .RES_LO(RES_LO),
        .ZO(ZO), .VO(VO), .NO(NO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one request from idle (called at posedge+1) and wait for DONE.
    // Operand inputs are scrambled right after accept. Returns cycles from
    // the accept edge to the DONE edge (40 means no DONE seen).
    task automatic do_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, output int lat);
        START = 1'b1; MODE = m; A = a; B = b; C = c;
        @(posedge CLK); #1;
        START = 1'b0; A = 8'hA5; B = 8'h5A; C = 8'h3C; MODE = 2'b11;
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (DONE) break;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; START = 1'b1; MODE = 2'b00; A = 8'h11; B = 8'h22; C = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({BUSY, DONE, RES_HI, RES_LO, ZO, VO, NO} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_state got %h exp 000000", {BUSY, DONE, RES_HI, RES_LO, ZO, VO, NO});
        end
        START = 1'b0; RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_umul;
        int lat;
        logic [1:0] modes [3] = '{2'b00, 2'b00, 2'b11};
        logic [7:0] as [3]    = '{8'hFF, 8'h0D, 8'hFF};
        logic [7:0] bs [3]    = '{8'hFF, 8'h0B, 8'h02};
        logic [18:0] exps [3] = '{{16'hFE01, 3'b001}, {16'h008F, 3'b100}, {16'h01FE, 3'b000}};
        for (int i = 0; i < 3; i++) begin
            do_op(modes[i], as[i], bs[i], 8'h77, lat);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL umul_latency[%0d] got %0d exp 8", i, lat);
            end
            n_checks++;
            if ({RES_HI, RES_LO, ZO, VO, NO} !== exps[i]) begin
                n_fail++;
                $display("FAIL umul_result[%0d] got %h exp %h", i, {RES_HI, RES_LO, ZO, VO, NO}, exps[i]);
            end
        end
    endtask

    task automatic test_smul;
        int lat;
        logic [7:0] as [3]    = '{8'hFF, 8'h80, 8'h05};
        logic [7:0] bs [3]    = '{8'h02, 8'h80, 8'hFD};
        logic [18:0] exps [3] = '{{16'hFFFE, 3'b001}, {16'h4000, 3'b000}, {16'hFFF1, 3'b001}};
        for (int i = 0; i < 3; i++) begin
            do_op(2'b01, as[i], bs[i], 8'h00, lat);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL smul_latency[%0d] got %0d exp 9", i, lat);
            end
            n_checks++;
            if ({RES_HI, RES_LO, ZO, VO, NO} !== exps[i]) begin
                n_fail++;
                $display("FAIL smul_result[%0d] got %h exp %h", i, {RES_HI, RES_LO, ZO, VO, NO}, exps[i]);
            end
        end
    endtask

    task automatic test_div;
        int lat;
        logic [7:0] cs [5]    = '{8'h12, 8'h00, 8'h7F, 8'h80, 8'h12};
        logic [7:0] as [5]    = '{8'h34, 8'h05, 8'hFF, 8'h00, 8'h34};
        logic [7:0] bs [5]    = '{8'h56, 8'h07, 8'h80, 8'h02, 8'h00};
        // {RES_HI (remainder), RES_LO (quotient), ZO, VO, NO}
        logic [18:0] exps [5] = '{{16'h1036, 3'b000}, {16'h0500, 3'b100}, {16'h7FFF, 3'b001},
                                  {16'h80FF, 3'b011}, {16'h12FF, 3'b011}};
        for (int i = 0; i < 5; i++) begin
            do_op(2'b10, as[i], bs[i], cs[i], lat);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL div_latency[%0d] got %0d exp 9", i, lat);
            end
            n_checks++;
            if ({RES_HI, RES_LO, ZO, VO, NO} !== exps[i]) begin
                n_fail++;
                $display("FAIL div_result[%0d] got %h exp %h", i, {RES_HI, RES_LO, ZO, VO, NO}, exps[i]);
            end
        end
    endtask

    // A second START during BUSY must be ignored and produce a single DONE.
    task automatic test_busy_ignore;
        int lat;
        int n_done;
        START = 1'b1; MODE = 2'b00; A = 8'h03; B = 8'h04; C = 8'h00;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (lat == 3) begin
                START = 1'b1; MODE = 2'b10; A = 8'hAA; B = 8'h55; C = 8'h00;
            end else begin
                START = 1'b0;
            end
            if (DONE) break;
        end
        START = 1'b0;
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL ignore_latency got %0d exp 8", lat);
        end
        n_checks++;
        if ({RES_HI, RES_LO, ZO, VO, NO} !== {16'h000C, 3'b100}) begin
            n_fail++;
            $display("FAIL ignore_result got %h exp %h", {RES_HI, RES_LO, ZO, VO, NO}, {16'h000C, 3'b100});
        end
        n_done = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL ignore_extra_activity got %0d cycles exp 0", n_done);
        end
    endtask

    // START in the DONE cycle is accepted; results hold while busy.
    task automatic test_back_to_back;
        int lat;
        int held_bad;
        do_op(2'b00, 8'h12, 8'h10, 8'h00, lat);
        n_checks++;
        if ({RES_HI, RES_LO} !== 16'h0120) begin
            n_fail++;
            $display("FAIL b2b_first got %h exp 0120", {RES_HI, RES_LO});
        end
        START = 1'b1; MODE = 2'b01; A = 8'hFE; B = 8'h03; C = 8'h00;
        @(posedge CLK); #1;
        START = 1'b0; A = 8'h00; B = 8'h00;
        n_checks++;
        if ({BUSY, DONE} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept busy/done got %b exp 10", {BUSY, DONE});
        end
        lat = 0;
        held_bad = 0;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (DONE) break;
            if ({RES_HI, RES_LO, ZO, VO, NO} !== {16'h0120, 3'b000}) held_bad++;
        end
        n_checks++;
        if (held_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_hold got %0d changed cycles exp 0", held_bad);
        end
        n_checks++;
        if (lat !== 9 || {RES_HI, RES_LO, ZO, VO, NO} !== {16'hFFFA, 3'b001}) begin
            n_fail++;
            $display("FAIL b2b_second got lat %0d res %h exp lat 9 res %h", lat,
                     {RES_HI, RES_LO, ZO, VO, NO}, {16'hFFFA, 3'b001});
        end
        @(posedge CLK); #1;
    endtask

    // Reset during a division aborts it; restart right after release works.
    task automatic test_reset_abort;
        int lat;
        int n_done;
        START = 1'b1; MODE = 2'b10; A = 8'h34; B = 8'h56; C = 8'h12;
        @(posedge CLK); #1;
        START = 1'b0;
        n_done = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (DONE) n_done++;
        end
        RST_N = 1'b0;
        START = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            if (DONE) n_done++;
        end
        n_checks++;
        if ({BUSY, DONE, RES_HI, RES_LO, ZO, VO, NO} !== 21'h0) begin
            n_fail++;
            $display("FAIL abort_state got %h exp 000000", {BUSY, DONE, RES_HI, RES_LO, ZO, VO, NO});
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_done got %0d pulses exp 0", n_done);
        end
        RST_N = 1'b1; MODE = 2'b10; A = 8'h64; B = 8'h07; C = 8'h00;
        @(posedge CLK); #1;
        START = 1'b0;
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_accept busy got %b exp 1", BUSY);
        end
        lat = 1;
        while (lat < 40) begin
            @(posedge CLK); #1;
            if (DONE) break;
            lat++;
        end
        n_checks++;
        if (lat !== 9 || {RES_HI, RES_LO, ZO, VO, NO} !== {16'h020E, 3'b000}) begin
            n_fail++;
            $display("FAIL restart_result got lat %0d res %h exp lat 9 res %h", lat,
                     {RES_HI, RES_LO, ZO, VO, NO}, {16'h020E, 3'b000});
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; MODE = 2'b00; A = '0; B = '0; C = '0;
        test_reset();
        test_umul();
        test_smul();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_muldiv_w.md
SEQ_MULDIV_W -- requirements
Module: seq_muldiv_w

Interface
REQ-001 Parameter W, default 8, operand width in bits; legal range 4..32.
REQ-002 Parameter SIGNED_EN, default 1, enables signed-multiply mode when 1; when 0, MODE=01 executes as unsigned multiply.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 START  in  1  request; sampled only when BUSY=0.
REQ-006 MODE  in  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 reserved (treated as 00).
REQ-007 A  in  W  multiplicand / dividend low half.
REQ-008 B  in  W  multiplier / divisor.
REQ-009 C  in  W  dividend high half (div only; ignored for mul).
REQ-010 BUSY  out  1  operation in progress.
REQ-011 DONE  out  1  one-cycle pulse, result valid.
REQ-012 RES_HI  out  W  mul: product[2W-1:W]; div: remainder.
REQ-013 RES_LO  out  W  mul: product[W-1:0]; div: quotient.
REQ-014 ZO  out  1  zero flag.
REQ-015 VO  out  1  overflow flag.
REQ-016 NO  out  1  negative flag.

Function
REQ-017 Accept: START=1 while BUSY=0 captures A, B, C, MODE into internal registers; BUSY=1 from the next cycle.
REQ-018 START while BUSY=1 is ignored; captured operands are unaffected by input changes after accept.
REQ-019 Latency: mul W cycles, signed mul W+1 cycles (final sign fix), div W+1 cycles, counted from the accept edge to the edge raising DONE.
REQ-020 On the DONE edge: BUSY=0, outputs updated; DONE high exactly one cycle.
REQ-021 Back-to-back: START asserted in the DONE cycle is accepted (BUSY=0 then).
REQ-022 RES_HI/RES_LO/flags hold the last result until the next DONE; they do not change during BUSY.
REQ-023 Unsigned mul: shift-add, one multiplier bit per cycle LSB-first; product = A*B exact in 2W bits.
REQ-024 Signed mul: two's-complement operands; magnitudes multiplied, product negated in the extra cycle when signs differ; exact 2W-bit result.
REQ-025 Div: restoring, one quotient bit per cycle MSB-first over the 2W-bit dividend {C,A}; quotient W bits, remainder W bits, remainder < B.
REQ-026 Div overflow: C >= B (includes B=0) detected at accept; VO=1, RES_LO all ones, RES_HI=C; latency still W+1.
REQ-027 Flags, mul: ZO=(RES_HI==0), NO=RES_HI[W-1], VO=0.
REQ-028 Flags, div: ZO=(RES_LO==0), NO=RES_LO[W-1], VO per REQ-026.
REQ-029 Internal cycle counter width ceil(log2(W+2)); no wrap beyond final count.

Reset
REQ-030 RST_N=0 at any edge: BUSY=0, DONE=0, RES_HI=RES_LO=0, ZO=VO=NO=0, counter and operand registers cleared.
REQ-031 Reset mid-operation aborts: no DONE, operation lost; START in the first cycle after RST_N=1 is accepted.
REQ-032 START is ignored while RST_N=0.

Verification (W=8)
REQ-033 MODE=00, A=0xFF, B=0xFF -> DONE 8 cycles after accept, RES_HI=0xFE, RES_LO=0x01, ZO=0, NO=1.
REQ-034 MODE=01, A=0xFF, B=0x02 -> DONE after 9 cycles, {RES_HI,RES_LO}=0xFFFE, NO=1; MODE=00 same operands -> 0x01FE.
REQ-035 MODE=10, C=0x12, A=0x34, B=0x56 -> DONE after 9 cycles, RES_LO=0x36, RES_HI=0x10, VO=0, ZO=0.
REQ-036 MODE=10, C=0x80, A=0x00, B=0x02 -> VO=1, RES_LO=0xFF, RES_HI=0x80; B=0x00 -> VO=1 likewise.
REQ-037 Accept op, pulse START again at cycle 3 -> ignored, single DONE; new START in the DONE cycle -> accepted, BUSY=1 next cycle.
REQ-038 Drop RST_N at cycle 4 of a div -> BUSY=0, outputs 0, no DONE; restart after release completes normally.
